// File: rtl/lock_pkg.sv
// Shared types and constants for the keypad code-entry lock.
// Timing defaults assume the 12 MHz hwclk.
package lock_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] DIGIT_MIN = 4'd1;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX = 4'd9;

  localparam int DEF_TIMEOUT_CYC = 60_000_000;
  localparam int DEF_OPEN_CYC    = 36_000_000;
  localparam int DEF_LOCKOUT_CYC = 120_000_000;
  localparam int DEF_MAX_TRIES   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
    S_FAIL,
    S_LOCKOUT
  } state_t;

  function automatic logic is_valid_digit(input logic [DIGIT_W-1:0] k);
    return (k >= DIGIT_MIN) && (k <= DIGIT_MAX);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_release_sync.sv
// Synchronises the key-held level and reports each release with the key code
// that was held; o_key_valid is a one-cycle pulse two edges after the raw fall.
module key_release_sync
  import lock_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [DIGIT_W-1:0] i_button,
  input  logic               i_bstate,
  output logic               o_key_valid,
  output logic [DIGIT_W-1:0] o_key_code
);

  logic               r_sync1;
  logic               r_sync2;
  logic               r_prev;
  logic [DIGIT_W-1:0] r_last_key;
  logic               w_release;

  assign w_release = r_prev & ~r_sync2;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1    <= 1'b0;
      r_sync2    <= 1'b0;
      r_prev     <= 1'b0;
      r_last_key <= '0;
    end else begin
      r_sync1 <= i_bstate;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      // Holds its value once the synced level drops, so it is the released key.
      if (r_sync2) begin
        r_last_key <= i_button;
      end
    end
  end

  assign o_key_valid = w_release;
  assign o_key_code  = r_last_key;

endmodule

// File: rtl/code_entry_checker.sv
// Collects CODE_LEN keypad digits, compares them with CODE and drives
// open / fail / lockout indications; all outputs are registered.
module code_entry_checker
  import lock_pkg::*;
#(
  parameter int          CODE_LEN    = 4,
  parameter logic [27:0] CODE        = 28'h0001234,
  parameter int          TIMEOUT_CYC = DEF_TIMEOUT_CYC,
  parameter int          OPEN_CYC    = DEF_OPEN_CYC,
  parameter int          MAX_TRIES   = DEF_MAX_TRIES,
  parameter int          LOCKOUT_CYC = DEF_LOCKOUT_CYC
) (
  input  logic               hwclk,
  input  logic               rst,
  input  logic [DIGIT_W-1:0] button,
  input  logic               bstate,
  output logic               unlocked,
  output logic               fail_pulse,
  output logic               locked_out,
  output logic               blink_start,
  output logic [2:0]         digit_count,
  output logic               busy
);

  localparam int TMR_MAX = max3(TIMEOUT_CYC, OPEN_CYC, LOCKOUT_CYC);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int TRY_W   = $clog2(MAX_TRIES + 1);
  localparam int BUF_W   = CODE_LEN * DIGIT_W;

  localparam logic [BUF_W-1:0] CODE_USED   = CODE[BUF_W-1:0];
  localparam logic [TMR_W-1:0] TIMEOUT_END = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [TMR_W-1:0] OPEN_END    = TMR_W'(OPEN_CYC - 1);
  localparam logic [TMR_W-1:0] LOCK_END    = TMR_W'(LOCKOUT_CYC - 1);
  localparam logic [TRY_W-1:0] TRY_LIMIT   = TRY_W'(MAX_TRIES);
  localparam logic [2:0]       COUNT_FULL  = 3'(CODE_LEN);

  logic               w_key_valid;
  logic [DIGIT_W-1:0] w_key_code;
  logic               w_key_ok;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [2:0]         r_count;
  logic [2:0]         w_count_nxt;
  logic [BUF_W-1:0]   r_buf;
  logic [BUF_W-1:0]   w_buf_nxt;
  logic [TMR_W-1:0]   r_timer;
  logic [TMR_W-1:0]   w_timer_nxt;
  logic [TRY_W-1:0]   r_tries;
  logic [TRY_W-1:0]   w_tries_nxt;
  logic               w_fail_nxt;
  logic               w_blink_nxt;

  logic               r_unlocked;
  logic               r_fail;
  logic               r_locked;
  logic               r_blink;
  logic               r_busy;

  key_release_sync u_key_sync (
    .i_clk       (hwclk),
    .i_rst       (rst),
    .i_button    (button),
    .i_bstate    (bstate),
    .o_key_valid (w_key_valid),
    .o_key_code  (w_key_code)
  );

  assign w_key_ok = w_key_valid && is_valid_digit(w_key_code);

  always_ff @(posedge hwclk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_count    <= '0;
      r_buf      <= '0;
      r_timer    <= '0;
      r_tries    <= '0;
      r_unlocked <= 1'b0;
      r_fail     <= 1'b0;
      r_locked   <= 1'b0;
      r_blink    <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_count    <= w_count_nxt;
      r_buf      <= w_buf_nxt;
      r_timer    <= w_timer_nxt;
      r_tries    <= w_tries_nxt;
      r_unlocked <= (w_state_nxt == S_OPEN);
      r_fail     <= w_fail_nxt;
      r_locked   <= (w_state_nxt == S_LOCKOUT);
      r_blink    <= w_blink_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_buf_nxt   = r_buf;
    w_timer_nxt = r_timer;
    w_tries_nxt = r_tries;
    w_fail_nxt  = 1'b0;
    w_blink_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_key_ok) begin
          w_buf_nxt                = '0;
          w_buf_nxt[DIGIT_W-1:0]   = w_key_code;
          w_count_nxt              = 3'd1;
          w_timer_nxt              = '0;
          w_state_nxt              = S_ENTRY;
        end
      end

      S_ENTRY: begin
        if (r_count == COUNT_FULL) begin
          w_timer_nxt = '0;
          w_state_nxt = S_CHECK;
        end else if (w_key_ok) begin
          // A release on the expiry cycle still counts and restarts the timer.
          for (int i = 0; i < CODE_LEN; i++) begin
            if (r_count == 3'(i)) begin
              w_buf_nxt[i*DIGIT_W +: DIGIT_W] = w_key_code;
            end
          end
          w_count_nxt = r_count + 3'd1;
          w_timer_nxt = '0;
        end else if (r_timer == TIMEOUT_END) begin
          w_buf_nxt   = '0;
          w_count_nxt = '0;
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end

      S_CHECK: begin
        w_count_nxt = '0;
        w_timer_nxt = '0;
        w_blink_nxt = 1'b1;
        if (r_buf == CODE_USED) begin
          w_tries_nxt = '0;
          w_state_nxt = S_OPEN;
        end else begin
          w_fail_nxt  = 1'b1;
          w_tries_nxt = (r_tries == TRY_LIMIT) ? r_tries : r_tries + TRY_W'(1);
          w_state_nxt = S_FAIL;
        end
      end

      S_OPEN: begin
        if (r_timer == OPEN_END) begin
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end

      S_FAIL: begin
        w_timer_nxt = '0;
        if (r_tries == TRY_LIMIT) begin
          w_tries_nxt = '0;
          w_state_nxt = S_LOCKOUT;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end

      S_LOCKOUT: begin
        if (r_timer == LOCK_END) begin
          w_timer_nxt = '0;
          w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt = r_timer + TMR_W'(1);
        end
      end

      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign unlocked    = r_unlocked;
  assign fail_pulse  = r_fail;
  assign locked_out  = r_locked;
  assign blink_start = r_blink;
  assign digit_count = r_count;
  assign busy        = r_busy;

endmodule

// File: tb/tb_code_entry_checker.sv
// Directed bench for code_entry_checker with short timers and code 1,2,3,4.
module tb_code_entry_checker;

  logic       hwclk;
  logic       rst;
  logic [3:0] button;
  logic       bstate;
  logic       unlocked;
  logic       fail_pulse;
  logic       locked_out;
  logic       blink_start;
  logic [2:0] digit_count;
  logic       busy;

  int n_checks;
  int n_errors;

  int mon_unl;
  int mon_fail;
  int mon_blink;
  int mon_lock;

  code_entry_checker #(
    .CODE_LEN    (4),
    .CODE        (28'h0004321),
    .TIMEOUT_CYC (50),
    .OPEN_CYC    (20),
    .MAX_TRIES   (3),
    .LOCKOUT_CYC (40)
  ) dut (
    .hwclk       (hwclk),
    .rst         (rst),
    .button      (button),
    .bstate      (bstate),
    .unlocked    (unlocked),
    .fail_pulse  (fail_pulse),
    .locked_out  (locked_out),
    .blink_start (blink_start),
    .digit_count (digit_count),
    .busy        (busy)
  );

  initial hwclk = 1'b0;
  always #5 hwclk = ~hwclk;

  initial begin
    mon_unl = 0; mon_fail = 0; mon_blink = 0; mon_lock = 0;
  end

  always @(negedge hwclk) begin
    mon_unl   = mon_unl   + int'(unlocked   === 1'b1);
    mon_fail  = mon_fail  + int'(fail_pulse === 1'b1);
    mon_blink = mon_blink + int'(blink_start === 1'b1);
    mon_lock  = mon_lock  + int'(locked_out === 1'b1);
  end

  task automatic snap(output int u, output int f, output int b, output int l);
    @(posedge hwclk); #1;
    u = mon_unl; f = mon_fail; b = mon_blink; l = mon_lock;
  endtask

  // Hold a key for four edges, release it, and return at the negedge
  // after the release has had time to be accepted.
  task automatic press(input logic [3:0] k);
    @(posedge hwclk); #1;
    button = k;
    bstate = 1'b1;
    repeat (4) @(posedge hwclk);
    #1 bstate = 1'b0;
    repeat (4) @(posedge hwclk);
    @(negedge hwclk);
  endtask

  task automatic enter_code(input logic [15:0] code);
    for (int i = 0; i < 4; i++) begin
      press(code[i*4 +: 4]);
    end
  endtask

  task automatic wait_idle(input int lim, output int cyc);
    cyc = 0;
    while (busy !== 1'b0 && cyc < lim) begin
      @(negedge hwclk);
      cyc++;
    end
  endtask

  task automatic pulse_reset();
    @(posedge hwclk); #1 rst = 1'b1;
    @(posedge hwclk); #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; button = 4'd0; bstate = 1'b0;
    #12;
    n_checks++;
    if ({unlocked, fail_pulse, locked_out, blink_start, digit_count, busy} !== 8'h00) begin
      n_errors++;
      $display("FAIL reset_outputs: got %b expected 00000000",
               {unlocked, fail_pulse, locked_out, blink_start, digit_count, busy});
    end
    @(posedge hwclk); #1 rst = 1'b0;
    repeat (3) @(negedge hwclk);
    n_checks++;
    if (busy !== 1'b0 || digit_count !== 3'd0) begin
      n_errors++;
      $display("FAIL reset_idle: got busy=%b count=%0d expected busy=0 count=0", busy, digit_count);
    end
  endtask

  task automatic test_correct_code();
    int u0, f0, b0, l0, cyc;
    snap(u0, f0, b0, l0);
    for (int i = 1; i <= 4; i++) begin
      press(4'(i));
      n_checks++;
      if (digit_count !== 3'(i)) begin
        n_errors++;
        $display("FAIL correct_count_%0d: got %0d expected %0d", i, digit_count, i);
      end
    end
    wait_idle(200, cyc);
    n_checks++;
    if (cyc >= 200) begin
      n_errors++;
      $display("FAIL correct_idle_timeout: got busy=%b expected 0 within 200 cycles", busy);
    end
    n_checks++;
    if (mon_unl - u0 !== 20) begin
      n_errors++;
      $display("FAIL correct_unlock_len: got %0d cycles expected 20", mon_unl - u0);
    end
    n_checks++;
    if (mon_blink - b0 !== 1 || mon_fail - f0 !== 0) begin
      n_errors++;
      $display("FAIL correct_pulses: got blink=%0d fail=%0d expected blink=1 fail=0",
               mon_blink - b0, mon_fail - f0);
    end
    n_checks++;
    if (unlocked !== 1'b0 || digit_count !== 3'd0) begin
      n_errors++;
      $display("FAIL correct_after: got unlocked=%b count=%0d expected 0 0", unlocked, digit_count);
    end
  endtask

  task automatic test_wrong_code();
    int u0, f0, b0, l0, cyc;
    snap(u0, f0, b0, l0);
    enter_code(16'h5321);
    n_checks++;
    if (digit_count !== 3'd4) begin
      n_errors++;
      $display("FAIL wrong_count: got %0d expected 4", digit_count);
    end
    wait_idle(50, cyc);
    n_checks++;
    if (cyc >= 50) begin
      n_errors++;
      $display("FAIL wrong_idle_timeout: got busy=%b expected 0 within 50 cycles", busy);
    end
    n_checks++;
    if (mon_fail - f0 !== 1 || mon_blink - b0 !== 1 || mon_unl - u0 !== 0) begin
      n_errors++;
      $display("FAIL wrong_pulses: got fail=%0d blink=%0d unl=%0d expected 1 1 0",
               mon_fail - f0, mon_blink - b0, mon_unl - u0);
    end
    n_checks++;
    if (digit_count !== 3'd0 || locked_out !== 1'b0) begin
      n_errors++;
      $display("FAIL wrong_after: got count=%0d locked=%b expected 0 0", digit_count, locked_out);
    end
  endtask

  task automatic test_lockout();
    int u0, f0, b0, l0, cyc;
    pulse_reset();
    snap(u0, f0, b0, l0);
    for (int e = 0; e < 2; e++) begin
      enter_code(16'h5321);
      wait_idle(50, cyc);
      n_checks++;
      if (cyc >= 50 || locked_out !== 1'b0) begin
        n_errors++;
        $display("FAIL lock_early_%0d: got busy=%b locked=%b expected idle unlocked", e, busy, locked_out);
      end
    end
    enter_code(16'h5321);
    cyc = 0;
    while (locked_out !== 1'b1 && cyc < 20) begin
      @(negedge hwclk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 20) begin
      n_errors++;
      $display("FAIL lock_enter: got locked=%b expected 1 within 20 cycles", locked_out);
    end
    press(4'd1);
    n_checks++;
    if (digit_count !== 3'd0 || locked_out !== 1'b1) begin
      n_errors++;
      $display("FAIL lock_ignore_key: got count=%0d locked=%b expected 0 1", digit_count, locked_out);
    end
    wait_idle(200, cyc);
    n_checks++;
    if (mon_lock - l0 !== 40) begin
      n_errors++;
      $display("FAIL lock_len: got %0d cycles expected 40", mon_lock - l0);
    end
    n_checks++;
    if (mon_fail - f0 !== 3 || mon_blink - b0 !== 3) begin
      n_errors++;
      $display("FAIL lock_pulses: got fail=%0d blink=%0d expected 3 3", mon_fail - f0, mon_blink - b0);
    end
    snap(u0, f0, b0, l0);
    enter_code(16'h4321);
    wait_idle(200, cyc);
    n_checks++;
    if (mon_unl - u0 !== 20) begin
      n_errors++;
      $display("FAIL lock_then_open: got %0d unlocked cycles expected 20", mon_unl - u0);
    end
  endtask

  task automatic test_timeout_invalid();
    int u0, f0, b0, l0;
    snap(u0, f0, b0, l0);
    press(4'd1);
    press(4'd2);
    n_checks++;
    if (digit_count !== 3'd2) begin
      n_errors++;
      $display("FAIL tmo_count: got %0d expected 2", digit_count);
    end
    repeat (40) @(negedge hwclk);
    n_checks++;
    if (digit_count !== 3'd2 || busy !== 1'b1) begin
      n_errors++;
      $display("FAIL tmo_early: got count=%0d busy=%b expected 2 1", digit_count, busy);
    end
    repeat (20) @(negedge hwclk);
    n_checks++;
    if (digit_count !== 3'd0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL tmo_expired: got count=%0d busy=%b expected 0 0", digit_count, busy);
    end
    n_checks++;
    if (mon_fail - f0 !== 0 || mon_blink - b0 !== 0) begin
      n_errors++;
      $display("FAIL tmo_no_pulse: got fail=%0d blink=%0d expected 0 0", mon_fail - f0, mon_blink - b0);
    end
    press(4'd0);
    n_checks++;
    if (digit_count !== 3'd0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL invalid_0: got count=%0d busy=%b expected 0 0", digit_count, busy);
    end
    press(4'd12);
    n_checks++;
    if (digit_count !== 3'd0 || busy !== 1'b0) begin
      n_errors++;
      $display("FAIL invalid_12: got count=%0d busy=%b expected 0 0", digit_count, busy);
    end
  endtask

  task automatic test_reset_mid();
    int u0, f0, b0, l0, cyc;
    press(4'd1);
    press(4'd2);
    press(4'd3);
    n_checks++;
    if (digit_count !== 3'd3) begin
      n_errors++;
      $display("FAIL rmid_count: got %0d expected 3", digit_count);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({unlocked, fail_pulse, locked_out, blink_start, digit_count, busy} !== 8'h00) begin
      n_errors++;
      $display("FAIL rmid_entry_outputs: got %b expected 00000000",
               {unlocked, fail_pulse, locked_out, blink_start, digit_count, busy});
    end
    @(posedge hwclk); #1 rst = 1'b0;
    enter_code(16'h4321);
    cyc = 0;
    while (unlocked !== 1'b1 && cyc < 20) begin
      @(negedge hwclk);
      cyc++;
    end
    n_checks++;
    if (cyc >= 20) begin
      n_errors++;
      $display("FAIL rmid_open: got unlocked=%b expected 1 within 20 cycles", unlocked);
    end
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({unlocked, fail_pulse, locked_out, blink_start, digit_count, busy} !== 8'h00) begin
      n_errors++;
      $display("FAIL rmid_open_outputs: got %b expected 00000000",
               {unlocked, fail_pulse, locked_out, blink_start, digit_count, busy});
    end
    @(posedge hwclk); #1 rst = 1'b0;
    snap(u0, f0, b0, l0);
    enter_code(16'h4321);
    wait_idle(200, cyc);
    n_checks++;
    if (mon_unl - u0 !== 20) begin
      n_errors++;
      $display("FAIL rmid_reopen: got %0d unlocked cycles expected 20", mon_unl - u0);
    end
    snap(u0, f0, b0, l0);
    for (int e = 0; e < 4; e++) begin
      if (e == 2) pulse_reset();
      enter_code(16'h5321);
      wait_idle(100, cyc);
    end
    n_checks++;
    if (mon_lock - l0 !== 0 || locked_out !== 1'b0) begin
      n_errors++;
      $display("FAIL rmid_tries_cleared: got lock_cycles=%0d locked=%b expected 0 0",
               mon_lock - l0, locked_out);
    end
    n_checks++;
    if (mon_fail - f0 !== 4) begin
      n_errors++;
      $display("FAIL rmid_fail_count: got %0d expected 4", mon_fail - f0);
    end
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_correct_code();
    test_wrong_code();
    test_lockout();
    test_timeout_invalid();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/code_entry_checker.md
Name: code_entry_checker

Overview:
- Sits directly downstream of the keypad decoder (`enterDigit`).
- Consumes the decoder's `button[3:0]` code and its `bstate` key-held level. Collects a fixed-length digit sequence and compares it with a stored combination.
- Drives lock status, fail and lockout indications, plus a one-cycle `blink_start` pulse for the LED blinker.
- Status outputs are also intended for the UART status byte.

Parameters:
- CODE_LEN, 4, number of digits per entry (1..7).
- CODE, 28'h0001234, combination packed 4 bits per digit. The digit entered first is in the least-significant nibble used, i.e. CODE[3:0] is digit 0. Only the low CODE_LEN*4 bits are used.
- TIMEOUT_CYC, 60000000, idle cycles allowed between key releases during ENTRY (5 s at 12 MHz).
- OPEN_CYC, 36000000, cycles `unlocked` stays high (3 s).
- MAX_TRIES, 3, consecutive failed entries that trigger lockout.
- LOCKOUT_CYC, 120000000, lockout duration (10 s).

Ports:
- hwclk, in, 1, 12 MHz system clock.
- rst, in, 1, reset, asynchronous, active-high.
- button, in, 4, key code from the keypad decoder. Valid digits are 1..9; all other values are ignored.
- bstate, in, 1, high while a key is held. A falling edge marks the key release.
- unlocked, out, 1, high while in OPEN.
- fail_pulse, out, 1, one-cycle pulse on a wrong code.
- locked_out, out, 1, high while in LOCKOUT.
- blink_start, out, 1, one-cycle pulse on entering OPEN or FAIL.
- digit_count, out, 3, number of digits accepted so far in the current entry.
- busy, out, 1, high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, any time, including mid-entry):
  - All outputs go to 0.
  - State goes to IDLE; digit buffer, try counter and timers clear.
  - bstate synchroniser flops reset to 0.
- Input capture:
  - bstate passes through a 2-flop synchroniser, then an edge detector. Release is detected when the synced value is 1 in the previous cycle and 0 in the current one.
  - While synced bstate=1, `button` is registered every cycle into last_key.
  - On release, last_key is the candidate digit. Release-to-accept latency is 3 hwclk cycles from the raw bstate fall.
- States: IDLE, ENTRY, CHECK, OPEN, FAIL, LOCKOUT.
- IDLE:
  - A valid release stores the digit in slot 0, sets digit_count=1 and moves to ENTRY.
  - An invalid code (0, 10..15) is ignored and digit_count stays 0.
- ENTRY:
  - Each valid release stores the digit in slot digit_count and increments digit_count.
  - When digit_count reaches CODE_LEN, move to CHECK on the next cycle.
  - The idle timer resets on every valid release. When it reaches TIMEOUT_CYC with no release, clear the buffer, set digit_count=0 and return to IDLE. A timeout does not pulse fail and does not count as a try.
- CHECK (1 cycle): compare the buffer with CODE[CODE_LEN*4-1:0].
  - Match: move to OPEN, pulse blink_start, clear the try counter.
  - Mismatch: move to FAIL, pulse fail_pulse and blink_start, increment the try counter (saturating at MAX_TRIES).
  - digit_count clears to 0 on leaving CHECK.
- OPEN:
  - unlocked=1 for exactly OPEN_CYC cycles, then IDLE.
  - Key releases are ignored.
- FAIL (1 cycle): if try counter == MAX_TRIES, move to LOCKOUT and clear the counter; otherwise move to IDLE.
- LOCKOUT:
  - locked_out=1 for exactly LOCKOUT_CYC cycles, then IDLE.
  - All releases are ignored.
- Releases arriving in CHECK or FAIL are dropped, not queued.
- Simultaneous timeout expiry and valid release in ENTRY: the release wins (the digit is accepted and the timer restarts).
- Timer widths are sized by $clog2 of the largest of TIMEOUT_CYC, OPEN_CYC and LOCKOUT_CYC. One shared timer is allowed because these states are mutually exclusive.
- All outputs are registered. Pulses are exactly one cycle wide.

Decomposition:
- Shared package `lock_pkg`:
  - State enum/localparams.
  - DIGIT_W=4.
  - Valid-digit range constants (1..9).
  - Default timing constants at the 12 MHz base.
- One natural sub-module: `key_release_sync`, containing the 2-flop synchroniser, edge detector and last_key capture. Outputs are key_valid (1-cycle pulse) and key_code[3:0].
- The FSM, buffer, comparator and timers stay in code_entry_checker.

Test Plan (bench overrides TIMEOUT_CYC=50, OPEN_CYC=20, MAX_TRIES=3, LOCKOUT_CYC=40; CODE=16'h4321 with CODE_LEN=4):
1. Correct code: press/release 1,2,3,4 → digit_count steps 1..4. In CHECK, one blink_start pulse. unlocked=1 for exactly 20 cycles, then busy=0.
2. Wrong code: enter 1,2,3,5 → fail_pulse and blink_start each high exactly 1 cycle. unlocked stays 0 and the FSM returns to IDLE.
3. Lockout: three wrong entries → after the third FAIL, locked_out=1 for 40 cycles. Releases during lockout leave digit_count=0. A subsequent correct entry unlocks.
4. Timeout and invalid keys:
   - Enter 1,2, then 50 idle cycles → digit_count returns to 0 with no fail_pulse.
   - Key code 0 or 12 from IDLE → no state change.
5. Reset mid-operation: assert rst asynchronously (between clock edges) during ENTRY at digit_count=3 and again during OPEN → every output is 0 immediately.
   - After release, entering 1,2,3,4 unlocks normally.
   - The try counter reads cleared: 2 fails, reset, 2 fails → no lockout.
